// File: rtl/ram_dual_hs.sv
`default_nettype none
// ============================================================================
//  Module   : ram_dual_hs
//  Purpose  : Simple dual-port RAM with one write port and one read port,
//             both using valid/ready handshakes. It supports byte-lane write
//             enables, a read latency of 1 or 2 cycles with output
//             backpressure, and a selectable read-during-write policy. The
//             memory is cleared after every reset, and out-of-range requests
//             are flagged.
//  Ports    : i_clk, i_rst                       clock, sync active-high reset
//             i_wr_valid/o_wr_ready              write handshake
//             i_wr_addr/i_wr_data/i_wr_be        write address, data, lanes
//             i_rd_valid/o_rd_ready/i_rd_addr    read request handshake
//             o_rd_valid/i_rd_ready/o_rd_data    read response handshake
//             o_init_done                        post-reset clear finished
//             o_addr_err                         1-cycle out-of-range pulse
//  Revision : 1.0 - initial release
// ============================================================================
module ram_dual_hs #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int ADDRESS = 5,
  parameter int BYTE_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int RDW_NEW = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [ADDRESS-1:0]        i_wr_addr,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic [WIDTH/BYTE_W-1:0]   i_wr_be,
  input  logic                      i_rd_valid,
  output logic                      o_rd_ready,
  input  logic [ADDRESS-1:0]        i_rd_addr,
  output logic                      o_rd_valid,
  input  logic                      i_rd_ready,
  output logic [WIDTH-1:0]          o_rd_data,
  output logic                      o_init_done,
  output logic                      o_addr_err
);

  localparam int NB = WIDTH / BYTE_W;
  // Depth widened by one bit so "addr >= DEPTH" also works when DEPTH == 2**ADDRESS.
  localparam logic [ADDRESS:0]   DEPTH_X  = (ADDRESS + 1)'(DEPTH);
  localparam logic [ADDRESS-1:0] LAST_PTR = ADDRESS'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             state;
  logic [ADDRESS-1:0] clr_ptr;
  logic               init_done;

  logic [WIDTH-1:0]   mem [DEPTH];

  logic               wr_fire;
  logic               wr_in;
  logic               wr_en;
  logic               rd_fire;
  logic               rd_in;
  logic               adv;
  logic [WIDTH-1:0]   rd_word;
  logic               rd_valid_q;
  logic [WIDTH-1:0]   rd_data_q;
  logic               addr_err;

  // --------------------------------------------------------------------------
  // Clear sequencer: one word is zeroed per cycle. The last word is written
  // in the same cycle that the state moves to RUN, so the clear lasts exactly
  // DEPTH cycles.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + ADDRESS'(1);
          if (clr_ptr == LAST_PTR) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  assign o_init_done = init_done;
  assign o_wr_ready  = init_done;

  // --------------------------------------------------------------------------
  // Write port
  // --------------------------------------------------------------------------
  assign wr_fire = i_wr_valid && o_wr_ready;
  assign wr_in   = ({1'b0, i_wr_addr} < DEPTH_X);
  assign wr_en   = wr_fire && wr_in;

  always_ff @(posedge i_clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) begin
          mem[i_wr_addr][k*BYTE_W +: BYTE_W] <= i_wr_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read port: handshake and array lookup
  // --------------------------------------------------------------------------
  // The pipeline advances whenever the output register is empty or drained.
  assign adv        = !rd_valid_q || i_rd_ready;
  assign o_rd_ready = init_done && adv;
  assign rd_fire    = i_rd_valid && o_rd_ready;
  assign rd_in      = ({1'b0, i_rd_addr} < DEPTH_X);

  // The array is only updated on the clock edge, so a plain lookup gives the
  // pre-write word. The new-data policy overlays the enabled write lanes.
  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      rd_word = mem[i_rd_addr];
      if ((RDW_NEW != 0) && wr_en && (i_wr_addr == i_rd_addr)) begin
        for (int k = 0; k < NB; k++) begin
          if (i_wr_be[k]) begin
            rd_word[k*BYTE_W +: BYTE_W] = i_wr_data[k*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline. All stages move together on adv and hold otherwise. The
  // output data register loads only with a valid word, so it stays stable
  // across bubbles and stalls.
  // --------------------------------------------------------------------------
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             s1_valid;
      logic [WIDTH-1:0] s1_data;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          s1_valid   <= 1'b0;
          s1_data    <= '0;
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else if (adv) begin
          s1_valid   <= rd_fire;
          if (rd_fire) begin
            s1_data <= rd_word;
          end
          rd_valid_q <= s1_valid;
          if (s1_valid) begin
            rd_data_q <= s1_data;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else if (adv) begin
          rd_valid_q <= rd_fire;
          if (rd_fire) begin
            rd_data_q <= rd_word;
          end
        end
      end
    end
  endgenerate

  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;

  // --------------------------------------------------------------------------
  // Out-of-range flag. This is a single registered OR, so an error on both
  // ports in the same cycle produces a single pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= (wr_fire && !wr_in) || (rd_fire && !rd_in);
    end
  end

  assign o_addr_err = addr_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_dual_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_dual_hs
//  Purpose  : Self-checking bench for ram_dual_hs. Two instances share the
//             write and read-ready stimulus:
//               dut0: DEPTH=32, RD_LAT=1, RDW_NEW=0
//               dut1: DEPTH=20, RD_LAT=2, RDW_NEW=1
//             Each instance has its own read-valid bit, so a stalled
//             instance never sees a request twice. A reference memory per
//             instance predicts read data, which is queued at acceptance
//             and compared at the output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dual_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [1:0]  rd_valid;
  logic [4:0]  rd_addr [2];
  logic        rd_rdy;
  logic [1:0]  wr_ready, rd_ready, rd_v, init_done, addr_err;
  logic [15:0] rd_data [2];

  always #5 clk = ~clk;

  ram_dual_hs #(.WIDTH(16), .DEPTH(32), .ADDRESS(5), .BYTE_W(8), .RD_LAT(1), .RDW_NEW(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready[0]), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_be(wr_be),
    .i_rd_valid(rd_valid[0]), .o_rd_ready(rd_ready[0]), .i_rd_addr(rd_addr[0]),
    .o_rd_valid(rd_v[0]), .i_rd_ready(rd_rdy), .o_rd_data(rd_data[0]),
    .o_init_done(init_done[0]), .o_addr_err(addr_err[0])
  );

  ram_dual_hs #(.WIDTH(16), .DEPTH(20), .ADDRESS(5), .BYTE_W(8), .RD_LAT(2), .RDW_NEW(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready[1]), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_be(wr_be),
    .i_rd_valid(rd_valid[1]), .o_rd_ready(rd_ready[1]), .i_rd_addr(rd_addr[1]),
    .o_rd_valid(rd_v[1]), .i_rd_ready(rd_rdy), .o_rd_data(rd_data[1]),
    .o_init_done(init_done[1]), .o_addr_err(addr_err[1])
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          dep [2];
  bit          rdw [2];
  logic [15:0] mm [2][32];
  logic [15:0] eq0 [$];
  logic [15:0] eq1 [$];
  logic [1:0]  err_pend;
  int          racc [2];
  int          iss;
  int          first_acc [2], first_val [2], last_val [2], beats [2];
  logic [15:0] last_pop [2];
  logic [15:0] held [2];
  bit          use_tab;
  logic [15:0] tab_exp;
  int          rlist [64];
  int          rn;
  int          ridx [2];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, d, act, want);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? eq0.size() : eq1.size();
  endfunction

  function automatic logic [15:0] qpop(input int d);
    if (d == 0) return eq0.pop_front();
    return eq1.pop_front();
  endfunction

  function automatic void qpush(input int d, input logic [15:0] v);
    if (d == 0) eq0.push_back(v);
    else        eq1.push_back(v);
  endfunction

  // Monitor and reference model. It runs on the falling edge, so every value
  // it reads is the one the DUT will see at the next rising edge.
  task automatic monitor();
    logic        w_acc, r_acc;
    logic [15:0] e;
    logic [4:0]  ra;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        if (d == 0) eq0.delete();
        else        eq1.delete();
        err_pend[d] = 1'b0;
        for (int a = 0; a < 32; a++) mm[d][a] = '0;
      end else begin
        w_acc = wr_valid && wr_ready[d];
        r_acc = rd_valid[d] && rd_ready[d];
        ra    = rd_addr[d];
        chk("addr_err", d, 32'(addr_err[d]), 32'(err_pend[d]));
        if (rd_v[d]) begin
          if (first_val[d] < 0) first_val[d] = cyc;
          last_val[d] = cyc;
        end
        if (rd_v[d] && rd_rdy) begin
          beats[d]++;
          if (qsize(d) == 0) begin
            total++;
            bad++;
            $display("FAIL rd_beat[%0d]: got unexpected beat %h want no beat", d, rd_data[d]);
          end else begin
            chk("rd_data", d, 32'(rd_data[d]), 32'(qpop(d)));
          end
          last_pop[d] = rd_data[d];
        end
        if (r_acc) begin
          racc[d]++;
          if (first_acc[d] < 0) first_acc[d] = cyc;
          if (int'(ra) >= dep[d]) begin
            e = '0;
          end else begin
            e = mm[d][ra];
            if (rdw[d] && w_acc && (wr_addr == ra)) begin
              for (int k = 0; k < 2; k++) if (wr_be[k]) e[k*8 +: 8] = wr_data[k*8 +: 8];
            end
          end
          qpush(d, use_tab ? tab_exp : e);
        end
        if (w_acc && (int'(wr_addr) < dep[d])) begin
          for (int k = 0; k < 2; k++) if (wr_be[k]) mm[d][wr_addr][k*8 +: 8] = wr_data[k*8 +: 8];
        end
        err_pend[d] = (w_acc && (int'(wr_addr) >= dep[d])) || (r_acc && (int'(ra) >= dep[d]));
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic drive_rd();
    for (int d = 0; d < 2; d++) begin
      rd_valid[d] = (ridx[d] < rn);
      rd_addr[d]  = (ridx[d] < rn) ? 5'(rlist[ridx[d]]) : 5'd0;
    end
  endtask

  // One clock cycle. A read request is withdrawn from an instance only once
  // that instance has accepted it.
  task automatic step();
    logic [1:0] acc;
    drive_rd();
    @(negedge clk);
    acc = rd_valid & rd_ready;
    if (wr_valid) begin
      for (int d = 0; d < 2; d++) chk("wr_ready", d, 32'(wr_ready[d]), 32'd1);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) if (acc[d]) ridx[d]++;
    drive_rd();
  endtask

  task automatic start_reads(input int first, input int n);
    for (int i = 0; i < n; i++) rlist[i] = first + i;
    rn      = n;
    ridx[0] = 0;
    ridx[1] = 0;
    iss    += n;
  endtask

  task automatic run_reads();
    int g = 0;
    while (((ridx[0] < rn) || (ridx[1] < rn)) && (g < 200)) begin
      step();
      g++;
    end
    if ((ridx[0] < rn) || (ridx[1] < rn)) begin
      total++;
      bad++;
      $display("FAIL rd_accept_timeout: got %0d/%0d accepted want %0d", ridx[0], ridx[1], rn);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (((qsize(0) != 0) || (qsize(1) != 0)) && (g < 50)) begin
      step();
      g++;
    end
    if ((qsize(0) != 0) || (qsize(1) != 0)) begin
      total++;
      bad++;
      $display("FAIL rd_drain_timeout: got %0d/%0d outstanding want 0", qsize(0), qsize(1));
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] dta, input logic [1:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = dta;
    wr_be    = be;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic count_init();
    int cnt [2];
    cnt[0] = 0;
    cnt[1] = 0;
    for (int k = 1; (k <= 100) && ((cnt[0] == 0) || (cnt[1] == 0)); k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) if (init_done[d] && (cnt[d] == 0)) cnt[d] = k;
    end
    chk("init_cycles", 0, 32'(cnt[0]), 32'd32);
    chk("init_cycles", 1, 32'(cnt[1]), 32'd20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [12];
    tab[0]  = '{wr:1, rd:0, addr:5'd3,  data:16'hA5A5, be:2'b11, exp_rd:16'h0000};
    tab[1]  = '{wr:1, rd:0, addr:5'd3,  data:16'h0011, be:2'b01, exp_rd:16'h0000};
    tab[2]  = '{wr:0, rd:1, addr:5'd3,  data:16'h0000, be:2'b00, exp_rd:16'hA511};
    tab[3]  = '{wr:1, rd:0, addr:5'd7,  data:16'h1234, be:2'b11, exp_rd:16'h0000};
    tab[4]  = '{wr:1, rd:0, addr:5'd5,  data:16'hFFFF, be:2'b10, exp_rd:16'h0000};
    tab[5]  = '{wr:0, rd:1, addr:5'd7,  data:16'h0000, be:2'b00, exp_rd:16'h1234};
    tab[6]  = '{wr:0, rd:1, addr:5'd5,  data:16'h0000, be:2'b00, exp_rd:16'hFF00};
    tab[7]  = '{wr:1, rd:0, addr:5'd5,  data:16'h00AB, be:2'b00, exp_rd:16'h0000};
    tab[8]  = '{wr:0, rd:1, addr:5'd5,  data:16'h0000, be:2'b00, exp_rd:16'hFF00};
    tab[9]  = '{wr:1, rd:0, addr:5'd10, data:16'hCAFE, be:2'b01, exp_rd:16'h0000};
    tab[10] = '{wr:0, rd:1, addr:5'd10, data:16'h0000, be:2'b00, exp_rd:16'h00FE};
    tab[11] = '{wr:0, rd:1, addr:5'd0,  data:16'h0000, be:2'b00, exp_rd:16'h0000};

    dep[0] = 32; dep[1] = 20;
    rdw[0] = 1'b0; rdw[1] = 1'b1;
    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_valid = '0; rd_addr[0] = '0; rd_addr[1] = '0; rd_rdy = 1'b1;
    use_tab = 1'b0; tab_exp = '0; rn = 0; ridx[0] = 0; ridx[1] = 0; iss = 0;
    for (int d = 0; d < 2; d++) begin
      racc[d] = 0; first_acc[d] = -1; first_val[d] = -1; last_val[d] = -1;
      beats[d] = 0; last_pop[d] = '0; err_pend[d] = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rd_valid", d, 32'(rd_v[d]), 32'd0);
      chk("rst_rd_data", d, 32'(rd_data[d]), 32'd0);
      chk("rst_init_done", d, 32'(init_done[d]), 32'd0);
      chk("rst_addr_err", d, 32'(addr_err[d]), 32'd0);
      chk("rst_wr_ready", d, 32'(wr_ready[d]), 32'd0);
      chk("rst_rd_ready", d, 32'(rd_ready[d]), 32'd0);
    end

    // Clear duration, then every word must read back as zero
    rst = 1'b0;
    count_init();
    start_reads(0, 32);
    run_reads();
    drain();

    // Table-driven writes and reads
    use_tab = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr_valid = tab[i].wr;
      wr_addr  = tab[i].addr;
      wr_data  = tab[i].data;
      wr_be    = tab[i].be;
      if (tab[i].rd) begin
        rlist[0] = int'(tab[i].addr);
        rn = 1; ridx[0] = 0; ridx[1] = 0; iss++;
        tab_exp = tab[i].exp_rd;
      end
      step();
      wr_valid = 1'b0;
    end
    drain();
    use_tab = 1'b0;

    // Back-to-back reads: latency and one beat per cycle
    for (int d = 0; d < 2; d++) begin
      first_acc[d] = -1; first_val[d] = -1; last_val[d] = -1; beats[d] = 0;
    end
    start_reads(0, 8);
    run_reads();
    drain();
    chk("latency", 0, 32'(first_val[0] - first_acc[0]), 32'd1);
    chk("latency", 1, 32'(first_val[1] - first_acc[1]), 32'd2);
    for (int d = 0; d < 2; d++) begin
      chk("burst_span", d, 32'(last_val[d] - first_val[d]), 32'd7);
      chk("burst_beats", d, 32'(beats[d]), 32'd8);
    end

    // Output backpressure
    for (int i = 8; i < 14; i++) wr(5'(i), 16'(16'h1000 + i), 2'b11);
    rd_rdy = 1'b0;
    start_reads(8, 6);
    repeat (3) step();
    held[0] = rd_data[0];
    held[1] = rd_data[1];
    repeat (5) begin
      step();
      for (int d = 0; d < 2; d++) begin
        chk("stall_rd_ready", d, 32'(rd_ready[d]), 32'd0);
        chk("stall_rd_valid", d, 32'(rd_v[d]), 32'd1);
        chk("stall_rd_data", d, 32'(rd_data[d]), 32'(held[d]));
      end
    end
    rd_rdy = 1'b1;
    run_reads();
    drain();

    // Same-cycle read and write at one address
    wr(5'd7, 16'h1234, 2'b11);
    start_reads(7, 1);
    wr(5'd7, 16'hBEEF, 2'b11);
    drain();
    chk("rdw_full", 0, 32'(last_pop[0]), 32'h1234);
    chk("rdw_full", 1, 32'(last_pop[1]), 32'hBEEF);
    start_reads(7, 1);
    wr(5'd7, 16'h00CD, 2'b01);
    drain();
    chk("rdw_lane", 0, 32'(last_pop[0]), 32'hBEEF);
    chk("rdw_lane", 1, 32'(last_pop[1]), 32'hBECD);

    // Out-of-range handling on the 20-word instance
    wr(5'd25, 16'h7777, 2'b11);
    chk("oor_err_pulse", 0, 32'(addr_err[0]), 32'd0);
    chk("oor_err_pulse", 1, 32'(addr_err[1]), 32'd1);
    step();
    chk("oor_err_clear", 1, 32'(addr_err[1]), 32'd0);
    rlist[0] = 25; rlist[1] = 5; rlist[2] = 9;
    rn = 3; ridx[0] = 0; ridx[1] = 0; iss += 3;
    run_reads();
    drain();
    start_reads(25, 1);
    wr(5'd26, 16'h5555, 2'b11);
    drain();

    // Reset with reads still in the pipeline
    start_reads(0, 2);
    step();
    step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_rd_valid", d, 32'(rd_v[d]), 32'd0);
      chk("midrst_init_done", d, 32'(init_done[d]), 32'd0);
      chk("midrst_rd_ready", d, 32'(rd_ready[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_init();
    start_reads(3, 1);
    run_reads();
    drain();
    chk("post_clear", 0, 32'(last_pop[0]), 32'd0);
    chk("post_clear", 1, 32'(last_pop[1]), 32'd0);

    for (int d = 0; d < 2; d++) begin
      chk("reads_accepted", d, 32'(racc[d]), 32'(iss));
      chk("outstanding", d, 32'(qsize(d)), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
